// File: rtl/broadcast_queue_pkg.sv
// rtl/broadcast_queue_pkg.sv - shared widths, defaults and entry/bus types for broadcast_queue
package broadcast_queue_pkg;

    localparam int BQ_NUM_FU     = 4;
    localparam int BQ_DATA_WIDTH = 32;
    localparam int BQ_TAG_WIDTH  = 7;
    localparam int BQ_DEPTH      = 8;

    // One buffered completion: execution tag plus result.
    typedef struct packed {
        logic [BQ_TAG_WIDTH-1:0]  tag;
        logic [BQ_DATA_WIDTH-1:0] data;
    } entry_t;

    // What the common data bus sees each cycle.
    typedef struct packed {
        logic                     valid;
        logic [BQ_TAG_WIDTH-1:0]  tag;
        logic [BQ_DATA_WIDTH-1:0] data;
    } cdb_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin single-grant arbiter with internal rotating pointer
module rr_arbiter #(
    parameter int NUM_FU = 4,
    localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_FU-1:0] req,
    input  logic              enable,
    output logic [NUM_FU-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              grant_valid
);

    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] rr_ptr_d;

    // First requester at or after rr_ptr (wrapping) wins; nothing when disabled.
    always_comb begin
        int j;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        j           = 0;
        if (enable) begin
            for (int k = 0; k < NUM_FU; k++) begin
                j = int'(rr_ptr_q) + k;
                if (j >= NUM_FU) begin
                    j = j - NUM_FU;
                end
                if (!grant_valid && req[j]) begin
                    grant_valid = 1'b1;
                    grant[j]    = 1'b1;
                    grant_idx   = IDX_W'(j);
                end
            end
        end
    end

    // Pointer moves just past the winner so it has lowest priority next time.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_valid) begin
            if (int'(grant_idx) == NUM_FU - 1) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx + IDX_W'(1);
            end
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/broadcast_queue.sv
// rtl/broadcast_queue.sv - accepts FU completions one per cycle and streams them to the CDB in order
module broadcast_queue
    import broadcast_queue_pkg::*;
#(
    parameter int NUM_FU     = BQ_NUM_FU,
    parameter int DATA_WIDTH = BQ_DATA_WIDTH,
    parameter int TAG_WIDTH  = BQ_TAG_WIDTH,
    parameter int DEPTH      = BQ_DEPTH,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_FU-1:0]            fu_done,
    input  logic [NUM_FU-1:0]            fu_ce,
    input  logic [NUM_FU*DATA_WIDTH-1:0] fu_result,
    input  logic [NUM_FU*TAG_WIDTH-1:0]  fu_tag,
    output logic [NUM_FU-1:0]            fu_queued,
    output logic                         cdb_valid,
    output logic [DATA_WIDTH-1:0]        cdb_data,
    output logic [TAG_WIDTH-1:0]         cdb_tag,
    input  logic                         cdb_ready,
    output logic [CNT_W-1:0]             count,
    output logic                         full,
    output logic                         empty
);

    localparam int ENT_W = TAG_WIDTH + DATA_WIDTH;
    localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0] claimed_q;
    logic [NUM_FU-1:0] claimed_d;
    logic [NUM_FU-1:0] cand;
    logic [NUM_FU-1:0] grant;
    logic [IDX_W-1:0]  grant_idx;
    logic              grant_valid;
    logic              arb_enable;

    logic [ENT_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_d;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;

    logic              push;
    logic              pop;
    logic [ENT_W-1:0]  push_entry;
    logic [ENT_W-1:0]  head_entry;

    // A unit is eligible once done, not yet acknowledged, and not being redispatched.
    always_comb begin
        cand       = fu_done & ~claimed_q & ~fu_ce;
        // Space is judged on current occupancy only, so a same-cycle pop never frees a slot early.
        arb_enable = rst & ~full;
    end

    rr_arbiter #(
        .NUM_FU(NUM_FU)
    ) u_arb (
        .clk        (clk),
        .rst        (rst),
        .req        (cand),
        .enable     (arb_enable),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid)
    );

    // Claim on acknowledge; redispatch releases the claim and wins over a same-cycle acknowledge.
    always_comb begin
        claimed_d = (claimed_q | grant) & ~fu_ce;
    end

    // Claimed bits register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            claimed_q <= '0;
        end else begin
            claimed_d_to_q: claimed_q <= claimed_d;
        end
    end

    // Select the granted unit's tag and result and decide push/pop for this cycle.
    always_comb begin
        push       = grant_valid;
        pop        = cdb_valid & cdb_ready;
        push_entry = {fu_tag[int'(grant_idx)*TAG_WIDTH +: TAG_WIDTH],
                      fu_result[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH]};
    end

    // Pointer and occupancy next-state; pointers wrap naturally at the power-of-two depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // FIFO control registers; reset discards whatever is buffered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care until written, reads are masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    // Head drive comes straight from storage so no fu_* input reaches the CDB combinationally.
    always_comb begin
        head_entry = mem_q[rd_ptr_q];
        count      = count_q;
        empty      = (count_q == '0);
        full       = (count_q == CNT_W'(DEPTH));
        cdb_valid  = ~empty;
        fu_queued  = grant;
        cdb_tag    = '0;
        cdb_data   = '0;
        if (cdb_valid) begin
            cdb_tag  = head_entry[ENT_W-1 -: TAG_WIDTH];
            cdb_data = head_entry[DATA_WIDTH-1:0];
        end
    end

endmodule
